// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-ST packet checker: width defaults,
// checker state encoding and err_flags bit positions.
package avalon_pkg;

    localparam int DATA_W_DEF     = 64;
    localparam int EMPTY_W_DEF    = 3;
    localparam int BYTES_PER_BEAT = DATA_W_DEF / 8;

    localparam int PKT_CNT_W  = 32;
    localparam int BYTE_CNT_W = 48;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } chk_state_t;

    localparam int ERR_ORPHAN       = 0;
    localparam int ERR_SOP_IN_PKT   = 1;
    localparam int ERR_EMPTY_NO_EOP = 2;
    localparam int ERR_SAT          = 3;

endpackage

// File: rtl/avst_pkt_checker_if.sv
// Sink and source Avalon-ST streams of the packet checker.
// slave = the checker itself, master = whatever drives and consumes it.
interface avst_pkt_checker_if
    import avalon_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int EMPTY_W = EMPTY_W_DEF
) ();

    logic               in_valid;
    logic               in_ready;
    logic               in_startofpacket;
    logic               in_endofpacket;
    logic [DATA_W-1:0]  in_data;
    logic [EMPTY_W-1:0] in_empty;

    logic               out_valid;
    logic               out_ready;
    logic               out_startofpacket;
    logic               out_endofpacket;
    logic [DATA_W-1:0]  out_data;
    logic [EMPTY_W-1:0] out_empty;

    modport slave (
        input  in_valid, in_startofpacket, in_endofpacket, in_data, in_empty,
        output in_ready,
        output out_valid, out_startofpacket, out_endofpacket, out_data, out_empty,
        input  out_ready
    );

    modport master (
        output in_valid, in_startofpacket, in_endofpacket, in_data, in_empty,
        input  in_ready,
        input  out_valid, out_startofpacket, out_endofpacket, out_data, out_empty,
        output out_ready
    );

endinterface

// File: rtl/avst_skid_buffer.sv
// Two-entry skid buffer: a main (output) register plus one skid register.
// in_ready is registered and means "skid register empty", so upstream only
// sees backpressure after the main register stalls while holding data.
module avst_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload
);

    logic         skid_valid;
    logic [W-1:0] skid_payload;

    // Main/skid register transfer and registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_payload  <= '0;
            skid_valid   <= 1'b0;
            skid_payload <= '0;
            in_ready     <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_payload <= skid_payload;
                skid_valid  <= 1'b0;
                in_ready    <= 1'b1;
            end
        end else if (in_valid && in_ready) begin
            if (out_valid && !out_ready) begin
                skid_payload <= in_payload;
                skid_valid   <= 1'b1;
                in_ready     <= 1'b0;
            end else begin
                out_payload <= in_payload;
                out_valid   <= 1'b1;
                in_ready    <= 1'b1;
            end
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            in_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/avst_pkt_checker.sv
// Avalon-ST packet framing checker with a skid-buffered forwarding path.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | between packets; a beat without sop is an orphan
//   S_IN_PKT | sop seen, waiting for eop; bytes held in pend_bytes
//
// byte_count only grows when a packet completes (or an orphan is forwarded),
// so the bytes of a packet abandoned by a second sop are never counted.
module avst_pkt_checker
    import avalon_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int EMPTY_W     = EMPTY_W_DEF,
    parameter int DROP_ORPHAN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    avst_pkt_checker_if.slave     bus,
    output logic [PKT_CNT_W-1:0]  pkt_count,
    output logic [BYTE_CNT_W-1:0] byte_count,
    output logic [3:0]            err_flags
);

    localparam int BPB = DATA_W / 8;
    localparam int PW  = DATA_W + EMPTY_W + 2;

    chk_state_t            state;
    logic [BYTE_CNT_W-1:0] pend_bytes;

    logic                  accept;
    logic                  drop;
    logic                  empty_err;
    logic [EMPTY_W-1:0]    fwd_empty;
    logic [PW-1:0]         skid_in;
    logic [PW-1:0]         skid_out;

    logic [BYTE_CNT_W-1:0] beat_bytes;
    logic [BYTE_CNT_W:0]   pend_sum;
    logic [BYTE_CNT_W-1:0] pend_sat;
    logic [BYTE_CNT_W-1:0] commit_amt;
    logic [BYTE_CNT_W:0]   byte_sum;
    logic [PKT_CNT_W:0]    pkt_sum;
    logic                  commit_en;
    logic                  pkt_en;
    logic                  sat_hit;

    assign accept    = bus.in_valid & bus.in_ready;
    assign drop      = (DROP_ORPHAN != 0) && (state == S_IDLE) && !bus.in_startofpacket;
    assign empty_err = !bus.in_endofpacket && (bus.in_empty != '0);
    assign fwd_empty = bus.in_endofpacket ? bus.in_empty : '0;
    assign skid_in   = {bus.in_startofpacket, bus.in_endofpacket, fwd_empty, bus.in_data};

    assign {bus.out_startofpacket, bus.out_endofpacket, bus.out_empty, bus.out_data} = skid_out;

    avst_skid_buffer #(.W(PW)) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (bus.in_valid & ~drop),
        .in_ready    (bus.in_ready),
        .in_payload  (skid_in),
        .out_valid   (bus.out_valid),
        .out_ready   (bus.out_ready),
        .out_payload (skid_out)
    );

    // Byte/packet arithmetic with saturation detection for the current beat.
    always_comb begin
        beat_bytes = bus.in_endofpacket ? (BYTE_CNT_W'(BPB) - BYTE_CNT_W'(bus.in_empty))
                                        : BYTE_CNT_W'(BPB);
        pend_sum   = {1'b0, pend_bytes} + {1'b0, beat_bytes};
        pend_sat   = pend_sum[BYTE_CNT_W] ? '1 : pend_sum[BYTE_CNT_W-1:0];
        commit_amt = (state == S_IN_PKT && !bus.in_startofpacket) ? pend_sat : beat_bytes;
        byte_sum   = {1'b0, byte_count} + {1'b0, commit_amt};
        pkt_sum    = {1'b0, pkt_count} + {{PKT_CNT_W{1'b0}}, 1'b1};
        pkt_en     = accept && bus.in_endofpacket &&
                     (bus.in_startofpacket || state == S_IN_PKT);
        commit_en  = pkt_en ||
                     (accept && state == S_IDLE && !bus.in_startofpacket && DROP_ORPHAN == 0);
        sat_hit    = (commit_en && byte_sum[BYTE_CNT_W]) ||
                     (pkt_en && pkt_sum[PKT_CNT_W]) ||
                     (accept && state == S_IN_PKT && !bus.in_startofpacket && pend_sum[BYTE_CNT_W]);
    end

    // Framing FSM, pending packet bytes, counters and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pend_bytes <= '0;
            pkt_count  <= '0;
            byte_count <= '0;
            err_flags  <= '0;
        end else if (accept) begin
            unique case (state)
                S_IDLE: begin
                    if (!bus.in_startofpacket) begin
                        err_flags[ERR_ORPHAN] <= 1'b1;
                    end else if (!bus.in_endofpacket) begin
                        state      <= S_IN_PKT;
                        pend_bytes <= beat_bytes;
                    end
                end
                S_IN_PKT: begin
                    if (bus.in_startofpacket) begin
                        err_flags[ERR_SOP_IN_PKT] <= 1'b1;
                        pend_bytes                <= beat_bytes;
                    end else begin
                        pend_bytes <= pend_sat;
                    end
                    if (bus.in_endofpacket) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (empty_err) begin
                err_flags[ERR_EMPTY_NO_EOP] <= 1'b1;
            end
            if (commit_en) begin
                byte_count <= byte_sum[BYTE_CNT_W] ? '1 : byte_sum[BYTE_CNT_W-1:0];
            end
            if (pkt_en) begin
                pkt_count <= pkt_sum[PKT_CNT_W] ? '1 : pkt_sum[PKT_CNT_W-1:0];
            end
            if (sat_hit) begin
                err_flags[ERR_SAT] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avst_pkt_checker.sv
// Directed bench for avst_pkt_checker (DATA_W=64, DROP_ORPHAN=1).
module tb_avst_pkt_checker;
    import avalon_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pkt_count;
    logic [47:0] byte_count;
    logic [3:0]  err_flags;

    avst_pkt_checker_if #(.DATA_W(64), .EMPTY_W(3)) bus ();

    avst_pkt_checker #(.DATA_W(64), .EMPTY_W(3), .DROP_ORPHAN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pkt_count  (pkt_count),
        .byte_count (byte_count),
        .err_flags  (err_flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int first_acc_cyc = 0;
    int first_out_cyc = 0;
    logic [127:0] got_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] mon_cur;
    logic [127:0] stall_pl;
    logic         stall_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack_beat(input logic sop, input logic eop,
                                               input logic [2:0] emp, input logic [63:0] d);
        return {59'd0, sop, eop, emp, d};
    endfunction

    // Output monitor: log delivered beats, verify payload holds during stalls.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            mon_cur = pack_beat(bus.out_startofpacket, bus.out_endofpacket, bus.out_empty, bus.out_data);
            if (bus.out_ready) begin
                if (got_q.size() == 0) first_out_cyc = cyc;
                got_q.push_back(mon_cur);
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("stall hold", mon_cur, stall_pl);
                stall_prev = 1'b1;
                stall_pl   = mon_cur;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic sop, input logic eop, input logic [2:0] emp,
                        input logic [63:0] d, input logic fwd);
        int t;
        bus.in_valid         = 1'b1;
        bus.in_startofpacket = sop;
        bus.in_endofpacket   = eop;
        bus.in_empty         = emp;
        bus.in_data          = d;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready) begin
            check("accept timeout", 128'(bus.in_ready), 128'(1));
            bus.in_valid = 1'b0;
            return;
        end
        if (n_acc == 0) first_acc_cyc = cyc;
        n_acc++;
        if (fwd) exp_q.push_back(pack_beat(sop, eop, eop ? emp : 3'd0, d));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        n_acc = 0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain_and_compare();
        repeat (4) @(posedge clk);
        #1;
        check("out beat count", 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("out beat", got_q[i], exp_q[i]);
    endtask

    task automatic check_counters(input logic [31:0] p, input logic [47:0] b, input logic [3:0] e);
        check("pkt_count", 128'(pkt_count), 128'(p));
        check("byte_count", 128'(byte_count), 128'(b));
        check("err_flags", 128'(err_flags), 128'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_startofpacket = 1'b0;
        bus.in_endofpacket = 1'b0;
        bus.in_empty = 3'd0;
        bus.in_data = 64'd0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 128'(bus.in_ready), 128'(0));
        check("reset out_valid", 128'(bus.out_valid), 128'(0));
        check("reset out payload",
              pack_beat(bus.out_startofpacket, bus.out_endofpacket, bus.out_empty, bus.out_data), 128'(0));
        check_counters(32'd0, 48'd0, 4'd0);
        check("reset fsm", 128'(dut.state), 128'(S_IDLE));
        reset = 1'b0;
        @(posedge clk); #1;
        check("in_ready after reset", 128'(bus.in_ready), 128'(1));

        // three-beat packet, last beat empty=3 -> 8+8+5 bytes
        send(1'b1, 1'b0, 3'd0, 64'hA000_0000_0000_0001, 1'b1);
        send(1'b0, 1'b0, 3'd0, 64'hA000_0000_0000_0002, 1'b1);
        send(1'b0, 1'b1, 3'd3, 64'hA000_0000_0000_0003, 1'b1);
        drain_and_compare();
        check("first out delay", 128'(first_out_cyc - first_acc_cyc), 128'(1));
        check_counters(32'd1, 48'd21, 4'b0000);

        // single-beat packet
        apply_reset();
        send(1'b1, 1'b1, 3'd0, 64'hB000_0000_0000_0001, 1'b1);
        drain_and_compare();
        check_counters(32'd1, 48'd8, 4'b0000);
        check("single fsm idle", 128'(dut.state), 128'(S_IDLE));

        // orphan beat is dropped
        apply_reset();
        send(1'b0, 1'b0, 3'd0, 64'hC000_0000_0000_0001, 1'b0);
        drain_and_compare();
        check_counters(32'd0, 48'd0, 4'b0001);

        // sop inside packet abandons the first packet
        apply_reset();
        send(1'b1, 1'b0, 3'd0, 64'hD000_0000_0000_0001, 1'b1);
        send(1'b0, 1'b0, 3'd0, 64'hD000_0000_0000_0002, 1'b1);
        send(1'b1, 1'b0, 3'd0, 64'hD000_0000_0000_0003, 1'b1);
        send(1'b0, 1'b1, 3'd0, 64'hD000_0000_0000_0004, 1'b1);
        drain_and_compare();
        check_counters(32'd1, 48'd16, 4'b0010);

        // 10-beat stream with a 5-cycle downstream stall
        apply_reset();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(i == 0, i == 9, 3'd0, 64'hE000_0000_0000_0000 + 64'(i), 1'b1);
            end
            begin
                int t = 0;
                while (n_acc < 3 && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                check("stream started", 128'(n_acc >= 3), 128'(1));
                bus.out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check("in_ready drop", 128'(bus.in_ready), 128'(0));
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain_and_compare();
        check_counters(32'd1, 48'd80, 4'b0000);

        // reset in mid-packet, then a clean two-beat packet
        apply_reset();
        send(1'b1, 1'b0, 3'd0, 64'hF000_0000_0000_0001, 1'b1);
        send(1'b0, 1'b0, 3'd0, 64'hF000_0000_0000_0002, 1'b1);
        apply_reset();
        send(1'b1, 1'b0, 3'd0, 64'hF100_0000_0000_0001, 1'b1);
        send(1'b0, 1'b1, 3'd0, 64'hF100_0000_0000_0002, 1'b1);
        drain_and_compare();
        check_counters(32'd1, 48'd16, 4'b0000);

        // nonzero empty without eop: flagged and forwarded with empty=0
        apply_reset();
        send(1'b1, 1'b0, 3'd5, 64'h1234_0000_0000_0001, 1'b1);
        send(1'b0, 1'b1, 3'd1, 64'h1234_0000_0000_0002, 1'b1);
        drain_and_compare();
        check_counters(32'd1, 48'd15, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avst_pkt_checker.md
AVST_PKT_CHECKER -- requirements
Module: avst_pkt_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 64, Avalon-ST data width in bits.
REQ-002 SHALL have parameter EMPTY_W, default 3, empty width, equal to log2(DATA_W/8).
REQ-003 SHALL have parameter DROP_ORPHAN, default 1; 1 = orphan beats are consumed and not forwarded.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid, in_startofpacket, in_endofpacket  input  1 each  Avalon-ST sink qualifiers.
REQ-008 in_data  input  DATA_W  sink data; in_empty  input  EMPTY_W  unused bytes on eop beat.
REQ-009 in_ready  output  1  sink backpressure, zero ready latency.
REQ-010 out_valid, out_startofpacket, out_endofpacket  output  1 each  source qualifiers.
REQ-011 out_data  output  DATA_W; out_empty  output  EMPTY_W  source payload.
REQ-012 out_ready  input  1  downstream backpressure, zero ready latency.
REQ-013 pkt_count  output  32  completed packets forwarded, saturating.
REQ-014 byte_count  output  48  payload bytes forwarded, saturating.
REQ-015 err_flags  output  4  sticky: [0] orphan beat, [1] sop inside packet, [2] empty nonzero without eop, [3] counter saturated.

Function
REQ-016 Accepted beat SHALL be defined as in_valid and in_ready high in the same cycle; non-accepted cycles SHALL change no state.
REQ-017 Forwarding path SHALL be a 2-entry skid buffer: 1-cycle latency from acceptance to out_valid, full throughput with out_ready held high.
REQ-018 in_ready SHALL be registered and SHALL equal "skid entry empty"; it SHALL drop only after out_ready is low while the main entry holds data.
REQ-019 out_* payload SHALL remain stable while out_valid and not out_ready.
REQ-020 Checker FSM SHALL have states IDLE and IN_PKT, advanced only on accepted beats.
REQ-021 IDLE, sop and eop: single-beat packet; stay IDLE; pkt_count +1.
REQ-022 IDLE, sop without eop: go to IN_PKT.
REQ-023 IDLE, no sop: orphan; set err_flags[0]; stay IDLE; drop the beat when DROP_ORPHAN=1, otherwise forward it.
REQ-024 IN_PKT, no sop, eop: go to IDLE; pkt_count +1.
REQ-025 IN_PKT, sop: set err_flags[1]; treat the beat as the start of a new packet; abandon the previous packet without counting it; stay IN_PKT, or go to IDLE if eop is also set (then pkt_count +1).
REQ-026 Any accepted beat with in_empty nonzero and eop low SHALL set err_flags[2] and be forwarded with empty forced to 0.
REQ-027 byte_count SHALL add DATA_W/8 - in_empty on forwarded eop beats and DATA_W/8 on other forwarded beats; dropped beats add nothing.
REQ-028 Counters SHALL saturate at all-ones and set err_flags[3]; they SHALL never wrap.
REQ-029 Counter and flag updates SHALL be visible the cycle after acceptance.

Reset
REQ-030 During reset, in_ready, out_valid, out_startofpacket, out_endofpacket, out_data, out_empty, pkt_count, byte_count and err_flags SHALL be 0, and FSM SHALL be IDLE.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted mid-packet SHALL discard buffered beats and the partial packet with no count change other than clearing.

Structure
REQ-033 Package avalon_pkg SHALL hold DATA_W/EMPTY_W defaults, BYTES_PER_BEAT, checker state enum and err_flags bit-index constants.
REQ-034 Skid buffer SHALL be a separate sub-module avst_skid_buffer, parameterised on payload width, instantiated once.

Verification
REQ-035 3-beat packet (sop; mid; eop, empty=3), out_ready=1 -> out beats 1 cycle delayed, pkt_count=1, byte_count=21, err_flags=0.
REQ-036 Single beat sop+eop, empty=0 -> pkt_count=1, byte_count=8, FSM IDLE.
REQ-037 Beat with no sop while IDLE, DROP_ORPHAN=1 -> no out_valid, err_flags=4'b0001, byte_count unchanged.
REQ-038 sop, mid, sop, eop -> err_flags[1]=1, pkt_count=1, byte_count=16.
REQ-039 out_ready low 5 cycles during a 10-beat stream -> in_ready drops within 2 cycles, no beat lost or duplicated, order preserved.
REQ-040 Reset pulsed after 2 beats of a 4-beat packet, then a clean 2-beat packet -> pkt_count=1, byte_count=16, err_flags=0.
